// File: rtl/axis_c2h_src_arbiter_if.sv
// -----------------------------------------------------------------------------
// axis_c2h_src_arbiter_if
// Bundles the requester-side and packer-side signals of the C2H source arbiter.
//
//   src_valid     [NUM_SRC]             per-source request, held until acked
//   src_data      [NUM_SRC*DATA_WIDTH]  source i at [i*DATA_WIDTH +: DATA_WIDTH]
//   src_ack       [NUM_SRC]             one-cycle capture pulse to the source
//   pk_data_valid                       to packer data_valid
//   pk_data       [DATA_WIDTH]          to packer data
//   pk_data_next                        from packer data_next (1 = packer idle)
//   grant_id      [SRC_ID_WIDTH]        source currently owning the packer
//   busy                                arbiter not idle
//   timeout_err                         sticky watchdog flag
//
// Modports: master = arbiter side, slave = producers/packer side.
// -----------------------------------------------------------------------------
interface axis_c2h_src_arbiter_if #(
    parameter int unsigned NUM_SRC      = 4,
    parameter int unsigned SRC_ID_WIDTH = 2,
    parameter int unsigned DATA_WIDTH   = 4064
);
    logic [NUM_SRC-1:0]            src_valid;
    logic [NUM_SRC*DATA_WIDTH-1:0] src_data;
    logic [NUM_SRC-1:0]            src_ack;
    logic                          pk_data_valid;
    logic [DATA_WIDTH-1:0]         pk_data;
    logic                          pk_data_next;
    logic [SRC_ID_WIDTH-1:0]       grant_id;
    logic                          busy;
    logic                          timeout_err;

    modport master (
        input  src_valid, src_data, pk_data_next,
        output src_ack, pk_data_valid, pk_data, grant_id, busy, timeout_err
    );

    modport slave (
        output src_valid, src_data, pk_data_next,
        input  src_ack, pk_data_valid, pk_data, grant_id, busy, timeout_err
    );
endinterface

// File: rtl/axis_c2h_src_arbiter.sv
// -----------------------------------------------------------------------------
// axis_c2h_src_arbiter
// Shares the single C2H AXIS packet packer between NUM_SRC record producers.
// A round-robin winner's record is latched into a holding register, offered to
// the packer with data_valid, and the arbiter then waits for data_next to drop
// (packer accepted) and rise again (packet done) before arbitrating again.
//
// Ports:
//   m_axis_c2h_aclk     sole clock
//   m_axis_c2h_aresetn  asynchronous active-low reset
//   bus (master)        request/ack, packer handshake and status signals
//
// Optional feature macro: ARB_TIMEOUT_EN
//   defined   : watchdog counter; after TIMEOUT_CYCLES cycles in ISSUE/WAIT_DONE
//               the packet is dropped, timeout_err is set (sticky) and the FSM
//               returns to IDLE.
//   undefined : no counter, timeout_err tied low, arbiter waits indefinitely.
// -----------------------------------------------------------------------------
module axis_c2h_src_arbiter #(
    parameter int unsigned NUM_SRC        = 4,
    parameter int unsigned SRC_ID_WIDTH   = 2,
    parameter int unsigned DATA_WIDTH     = 4064,
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic                   m_axis_c2h_aclk,
    input  logic                   m_axis_c2h_aresetn,
    axis_c2h_src_arbiter_if.master bus
);

    if (NUM_SRC < 2 || NUM_SRC > 16 || (2 ** SRC_ID_WIDTH) < NUM_SRC ||
        TIMEOUT_CYCLES == 0) begin : g_bad_params
        $error("axis_c2h_src_arbiter: illegal parameterisation");
    end

    // StWaitAccept is a reserved encoding and is never entered.
    typedef enum logic [1:0] {
        StIdle       = 2'd0,
        StIssue      = 2'd1,
        StWaitAccept = 2'd2,
        StWaitDone   = 2'd3
    } state_e;

    state_e                  r_state, w_state_nxt;
    logic                    r_pk_data_valid, w_pk_data_valid_nxt;
    logic [DATA_WIDTH-1:0]   r_pk_data, w_pk_data_nxt;
    logic [NUM_SRC-1:0]      r_src_ack, w_src_ack_nxt;
    logic [SRC_ID_WIDTH-1:0] r_grant_id, w_grant_id_nxt;
    logic [SRC_ID_WIDTH-1:0] r_rr_ptr, w_rr_ptr_nxt;
    logic                    r_busy, w_busy_nxt;

    logic                    w_hi_found, w_lo_found, w_any;
    logic [SRC_ID_WIDTH-1:0] w_hi_idx, w_lo_idx, w_winner;
    logic [DATA_WIDTH-1:0]   w_win_data;
    logic [NUM_SRC-1:0]      w_win_onehot;

`ifdef ARB_TIMEOUT_EN
    logic [31:0]             r_wd_cnt, w_wd_cnt_nxt;
    logic                    r_timeout_err, w_timeout_err_nxt;
`endif

    // Round robin: the first requester above rr_ptr wins; if there is none,
    // wrap around to the first requester at or below rr_ptr.
    always_comb begin
        w_hi_found = 1'b0;
        w_lo_found = 1'b0;
        w_hi_idx   = '0;
        w_lo_idx   = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (bus.src_valid[i]) begin
                if (SRC_ID_WIDTH'(i) > r_rr_ptr) begin
                    if (!w_hi_found) begin
                        w_hi_found = 1'b1;
                        w_hi_idx   = SRC_ID_WIDTH'(i);
                    end
                end else if (!w_lo_found) begin
                    w_lo_found = 1'b1;
                    w_lo_idx   = SRC_ID_WIDTH'(i);
                end
            end
        end
        w_any    = w_hi_found | w_lo_found;
        w_winner = w_hi_found ? w_hi_idx : w_lo_idx;
    end

    always_comb begin
        w_win_data   = '0;
        w_win_onehot = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (SRC_ID_WIDTH'(i) == w_winner) begin
                w_win_data      = bus.src_data[i*DATA_WIDTH +: DATA_WIDTH];
                w_win_onehot[i] = 1'b1;
            end
        end
    end

    always_comb begin
        w_state_nxt         = r_state;
        w_pk_data_valid_nxt = r_pk_data_valid;
        w_pk_data_nxt       = r_pk_data;
        w_src_ack_nxt       = '0;
        w_grant_id_nxt      = r_grant_id;
        w_rr_ptr_nxt        = r_rr_ptr;
`ifdef ARB_TIMEOUT_EN
        w_wd_cnt_nxt        = r_wd_cnt;
        w_timeout_err_nxt   = r_timeout_err;
`endif

        case (r_state)
            StIdle: begin
                w_pk_data_valid_nxt = 1'b0;
                if (w_any && bus.pk_data_next) begin
                    w_pk_data_nxt       = w_win_data;
                    w_grant_id_nxt      = w_winner;
                    w_rr_ptr_nxt        = w_winner;
                    w_src_ack_nxt       = w_win_onehot;
                    w_pk_data_valid_nxt = 1'b1;
                    w_state_nxt         = StIssue;
`ifdef ARB_TIMEOUT_EN
                    w_wd_cnt_nxt        = '0;
`endif
                end
            end
            StIssue: begin
                w_pk_data_valid_nxt = 1'b1;
                // data_next falling means the packer has taken the record.
                if (!bus.pk_data_next) begin
                    w_pk_data_valid_nxt = 1'b0;
                    w_state_nxt         = StWaitDone;
                end
            end
            StWaitDone: begin
                w_pk_data_valid_nxt = 1'b0;
                // Returning through IDLE guarantees a gap cycle between packets.
                if (bus.pk_data_next) begin
                    w_state_nxt = StIdle;
                end
            end
            default: begin
                w_pk_data_valid_nxt = 1'b0;
                w_state_nxt         = StIdle;
            end
        endcase

`ifdef ARB_TIMEOUT_EN
        if (r_state == StIssue || r_state == StWaitDone) begin
            w_wd_cnt_nxt = r_wd_cnt + 32'd1;
            if (w_wd_cnt_nxt == TIMEOUT_CYCLES) begin
                w_pk_data_valid_nxt = 1'b0;
                w_timeout_err_nxt   = 1'b1;
                w_state_nxt         = StIdle;
            end
        end
`endif

        w_busy_nxt = (w_state_nxt != StIdle);
    end

    always_ff @(posedge m_axis_c2h_aclk or negedge m_axis_c2h_aresetn) begin
        if (!m_axis_c2h_aresetn) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge m_axis_c2h_aclk or negedge m_axis_c2h_aresetn) begin
        if (!m_axis_c2h_aresetn) begin
            r_pk_data_valid <= 1'b0;
            r_pk_data       <= '0;
            r_src_ack       <= '0;
            r_grant_id      <= '0;
            // Pointer at the last source so that source 0 wins first.
            r_rr_ptr        <= SRC_ID_WIDTH'(NUM_SRC - 1);
            r_busy          <= 1'b0;
        end else begin
            r_pk_data_valid <= w_pk_data_valid_nxt;
            r_pk_data       <= w_pk_data_nxt;
            r_src_ack       <= w_src_ack_nxt;
            r_grant_id      <= w_grant_id_nxt;
            r_rr_ptr        <= w_rr_ptr_nxt;
            r_busy          <= w_busy_nxt;
        end
    end

`ifdef ARB_TIMEOUT_EN
    always_ff @(posedge m_axis_c2h_aclk or negedge m_axis_c2h_aresetn) begin
        if (!m_axis_c2h_aresetn) begin
            r_wd_cnt      <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            r_wd_cnt      <= w_wd_cnt_nxt;
            r_timeout_err <= w_timeout_err_nxt;
        end
    end

    assign bus.timeout_err = r_timeout_err;
`else
    assign bus.timeout_err = 1'b0;
`endif

    assign bus.pk_data_valid = r_pk_data_valid;
    assign bus.pk_data       = r_pk_data;
    assign bus.src_ack       = r_src_ack;
    assign bus.grant_id      = r_grant_id;
    assign bus.busy          = r_busy;

endmodule

// File: doc/axis_c2h_src_arbiter.md
Name: axis_c2h_src_arbiter

Overview:
- Shares the single C2H AXIS packet packer between NUM_SRC independent record producers.
- Selects a requester by round-robin and latches its record into a holding register.
- Drives the packer's data_valid/data handshake and waits for the packet to finish.
- Sits between the core-side trace producers and the packer, in the m_axis_c2h_aclk domain.

Parameters:
- NUM_SRC, 4, number of requesters (2..16).
- SRC_ID_WIDTH, 2, width of grant_id; must satisfy 2^SRC_ID_WIDTH >= NUM_SRC.
- DATA_WIDTH, 4064, record width, identical to the packer's data width.
- TIMEOUT_CYCLES, 4096, watchdog limit (used only with ARB_TIMEOUT_EN).

Ports:
- m_axis_c2h_aclk  in  1  sole clock.
- m_axis_c2h_aresetn  in  1  asynchronous active-low reset.
- src_valid  in  NUM_SRC  per-source request; held until acked.
- src_data  in  NUM_SRC*DATA_WIDTH  source i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- src_ack  out  NUM_SRC  one-cycle pulse: record captured, source may change data.
- pk_data_valid  out  1  to packer data_valid.
- pk_data  out  DATA_WIDTH  to packer data; held from register.
- pk_data_next  in  1  from packer data_next; 1 = packer idle.
- grant_id  out  SRC_ID_WIDTH  index of source currently owning the packer.
- busy  out  1  high in any state other than IDLE.
- timeout_err  out  1  sticky watchdog flag.

Behaviour:
- Reset: asynchronous, active-low; all registers clear immediately.
  - Reset values: state=IDLE; pk_data_valid=0; pk_data=0; src_ack=0; grant_id=0; busy=0; timeout_err=0; rr_ptr=NUM_SRC-1, so source 0 wins first.
  - Reset mid-packet abandons the packet without further handshake. The packer is on the same reset.
- State machine (registered) has four states: IDLE, ISSUE, WAIT_ACCEPT and WAIT_DONE.
- IDLE:
  - If any src_valid is high and pk_data_next==1, pick the first set bit scanning rr_ptr+1, rr_ptr+2, … with modulo-NUM_SRC wrap.
  - On the same edge: pk_data<=src_data[winner]; grant_id<=winner; rr_ptr<=winner; src_ack[winner]<=1 for exactly one cycle; pk_data_valid<=1; go to ISSUE.
  - If pk_data_next==0 in IDLE, do not grant.
- ISSUE: pk_data_valid stays 1 and pk_data stays stable. On the first cycle with pk_data_next==0, pk_data_valid<=0 and go to WAIT_DONE.
  - If pk_data_next stays 1, remain in ISSUE. The packer samples on its own schedule.
- WAIT_DONE: pk_data_valid=0. When pk_data_next returns to 1, go to IDLE.
  - Minimum one IDLE cycle between packets, so the packer can never resample a stale record.
- WAIT_ACCEPT: reserved encoding, never entered. An illegal state recovers to IDLE with pk_data_valid=0.
- Latency: request seen in IDLE → pk_data_valid high on the next edge. Grant-to-grant minimum is packer packet time + 2 cycles.
- Fairness: a continuously requesting source is skipped only while other requesters are served. Each waits at most NUM_SRC-1 packets.
- Simultaneous events:
  - src_valid deasserting during ISSUE/WAIT_DONE has no effect; the record is already latched.
  - A new request from the granted source is not re-granted until its round-robin turn.
- src_ack never pulses outside the IDLE→ISSUE transition. At most one ack bit is high per cycle.
- busy = (state != IDLE), registered alongside state.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - A 32-bit counter clears on entering ISSUE and increments each cycle in ISSUE or WAIT_DONE.
  - On reaching TIMEOUT_CYCLES: pk_data_valid<=0, timeout_err<=1 (sticky until reset), state<=IDLE.
  - Arbitration resumes once pk_data_next==1.
- Undefined: no counter exists. timeout_err is tied to 0 and the arbiter waits indefinitely.

Test Plan:
- Single source: src_valid=4'b0001, src_data[0]=A; packer model drops data_next 1 cycle after valid and raises it 8 cycles later → src_ack[0] pulses once, pk_data=A, grant_id=0, pk_data_valid high exactly 2 cycles, busy low 1 cycle after data_next rises.
- All four requesting continuously → grant order 0,1,2,3,0,1 with exactly one src_ack per packet and no source granted twice in a row.
- Sources 1 and 3 request, rr_ptr=1 → source 3 granted first, then 1.
- pk_data_next held 0 at IDLE with src_valid=4'b0100 → no grant and no ack until data_next=1, then grant_id=2 on the next edge.
- Assert m_axis_c2h_aresetn low during WAIT_DONE → all outputs zero immediately, without waiting for a clock edge. After release, source 0 has priority.
- With ARB_TIMEOUT_EN, TIMEOUT_CYCLES=16, packer holds data_next=0 forever → timeout_err=1 at cycle 16 after grant, state IDLE, pk_data_valid=0. Without the macro, busy stays 1 and timeout_err=0.
